// File: rtl/hit_judge.sv
// hit_judge -- whack-a-mole round referee.
//
// Runs one timed round: detects rising edges on the start key and the hole
// keys, judges each key edge against the lit hole, keeps score / miss / time
// counters and emits one-cycle pulses to the buzzer and mole generator.
//
// Ports
//   clk          rising-edge clock for all logic
//   rst          synchronous active-high reset
//   start        debounced start key level
//   keys         debounced hole key levels, one bit per hole
//   mole_pos     one-hot lit hole, all-zero when no mole is shown
//   correct_hit  pulse: exactly one key edge, on the lit hole
//   wrong_hit    pulse: any other key activity during a round
//   game_over    pulse: round ended (time out or too many misses)
//   mole_clear   pulse: request a new mole position
//   playing      high while a round is running
//   score        correct hits this round, saturates at 255
//   misses       wrong hits this round
//   seconds_left whole seconds remaining in the round
module hit_judge #(
   parameter int NUM_HOLES    = 4,
   parameter int CLK_HZ       = 50_000_000,
   parameter int GAME_SECONDS = 30,
   parameter int MAX_MISSES   = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [NUM_HOLES-1:0] keys,
   input  logic [NUM_HOLES-1:0] mole_pos,
   output logic                 correct_hit,
   output logic                 wrong_hit,
   output logic                 game_over,
   output logic                 mole_clear,
   output logic                 playing,
   output logic [7:0]           score,
   output logic [2:0]           misses,
   output logic [7:0]           seconds_left
);

   // Prescaler is wide enough for 0..CLK_HZ-1; keep at least one bit.
   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic                 start_q;
   logic [NUM_HOLES-1:0] keys_q;
   logic [PW-1:0]        presc_q, presc_d;
   logic [7:0]           secs_q, secs_d;
   logic [7:0]           score_q, score_d;
   logic [2:0]           misses_q, misses_d;
   logic                 correct_q, correct_d;
   logic                 wrong_q, wrong_d;
   logic                 over_q, over_d;
   logic                 clear_q, clear_d;

   logic                 start_edge;
   logic [NUM_HOLES-1:0] key_edge;
   logic                 single_edge;
   logic                 sec_tick;

   assign start_edge  = start & ~start_q;
   assign key_edge    = keys & ~keys_q;
   // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
   assign single_edge = (key_edge != '0) && ((key_edge & (key_edge - 1'b1)) == '0);
   assign sec_tick    = (presc_q == PRESC_MAX);

   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      secs_d    = secs_q;
      score_d   = score_q;
      misses_d  = misses_q;
      correct_d = 1'b0;
      wrong_d   = 1'b0;
      over_d    = 1'b0;
      clear_d   = 1'b0;

      case (state_q)
         IDLE, OVER: begin
            if (start_edge) begin
               state_d  = PLAY;
               presc_d  = '0;
               secs_d   = 8'(GAME_SECONDS);
               score_d  = '0;
               misses_d = '0;
            end
         end

         PLAY: begin
            if (sec_tick) begin
               presc_d = '0;
               if (secs_q != 8'd0) begin
                  secs_d = secs_q - 8'd1;
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end

            // Expiry takes priority over any key activity on the same cycle.
            if (sec_tick && (secs_q <= 8'd1)) begin
               secs_d  = 8'd0;
               state_d = OVER;
               over_d  = 1'b1;
            end else if (key_edge != '0) begin
               if (single_edge && ((key_edge & mole_pos) != '0)) begin
                  correct_d = 1'b1;
                  clear_d   = 1'b1;
                  if (score_q != 8'hFF) begin
                     score_d = score_q + 8'd1;
                  end
               end else begin
                  wrong_d  = 1'b1;
                  misses_d = misses_q + 3'd1;
                  if ((misses_q + 3'd1) == 3'(MAX_MISSES)) begin
                     state_d = OVER;
                     over_d  = 1'b1;
                  end
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         start_q   <= 1'b0;
         keys_q    <= '0;
         presc_q   <= '0;
         secs_q    <= '0;
         score_q   <= '0;
         misses_q  <= '0;
         correct_q <= 1'b0;
         wrong_q   <= 1'b0;
         over_q    <= 1'b0;
         clear_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         // Previous-level registers track the inputs in every state so that a
         // key held across a state change never appears as a fresh edge.
         start_q   <= start;
         keys_q    <= keys;
         presc_q   <= presc_d;
         secs_q    <= secs_d;
         score_q   <= score_d;
         misses_q  <= misses_d;
         correct_q <= correct_d;
         wrong_q   <= wrong_d;
         over_q    <= over_d;
         clear_q   <= clear_d;
      end
   end

   assign correct_hit  = correct_q;
   assign wrong_hit    = wrong_q;
   assign game_over    = over_q;
   assign mole_clear   = clear_q;
   assign playing      = (state_q == PLAY);
   assign score        = score_q;
   assign misses       = misses_q;
   assign seconds_left = secs_q;

endmodule

// File: tb/tb_hit_judge.sv
// Directed testbench for hit_judge (CLK_HZ=10, GAME_SECONDS=3, MAX_MISSES=3).
// A second instance with a long round is used only for score saturation.
module tb_hit_judge;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] keys;
   logic [3:0] mole_pos;

   logic       correct_hit, wrong_hit, game_over, mole_clear, playing;
   logic [7:0] score, seconds_left;
   logic [2:0] misses;

   logic       s_correct, s_wrong, s_over, s_clear, s_playing;
   logic [7:0] s_score, s_secs;
   logic [2:0] s_misses;

   int checks = 0;
   int errors = 0;

   hit_judge #(
      .NUM_HOLES(4), .CLK_HZ(10), .GAME_SECONDS(3), .MAX_MISSES(3)
   ) u_dut (
      .clk(clk), .rst(rst), .start(start), .keys(keys), .mole_pos(mole_pos),
      .correct_hit(correct_hit), .wrong_hit(wrong_hit), .game_over(game_over),
      .mole_clear(mole_clear), .playing(playing), .score(score),
      .misses(misses), .seconds_left(seconds_left)
   );

   hit_judge #(
      .NUM_HOLES(4), .CLK_HZ(1000), .GAME_SECONDS(3), .MAX_MISSES(3)
   ) u_dut_sat (
      .clk(clk), .rst(rst), .start(start), .keys(keys), .mole_pos(mole_pos),
      .correct_hit(s_correct), .wrong_hit(s_wrong), .game_over(s_over),
      .mole_clear(s_clear), .playing(s_playing), .score(s_score),
      .misses(s_misses), .seconds_left(s_secs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle; inputs are changed only after this.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reset, then start a round; leaves the DUT one cycle into PLAY.
   task automatic go_play;
      rst = 1'b1; start = 1'b0; keys = 4'b0000; mole_pos = 4'b0000;
      tick();
      rst = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; keys = 4'b0000; mole_pos = 4'b0000;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if ({correct_hit, wrong_hit, game_over, mole_clear, playing} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 00000", {correct_hit, wrong_hit, game_over, mole_clear, playing});
      end
      checks++;
      if ({score, misses, seconds_left} !== 19'd0) begin
         errors++;
         $display("FAIL reset_counts: score=%0d misses=%0d secs=%0d expected all 0", score, misses, seconds_left);
      end
      $display("reset: playing=%0d score=%0d misses=%0d secs=%0d", playing, score, misses, seconds_left);
   endtask

   task automatic test_timeout;
      logic early;
      logic [7:0] secs_at10;
      early = 1'b0;
      secs_at10 = 8'd0;
      start = 1'b1;
      tick();
      checks++;
      if (playing !== 1'b1 || seconds_left !== 8'd3) begin
         errors++;
         $display("FAIL start_round: playing=%0d secs=%0d expected 1 and 3", playing, seconds_left);
      end
      for (int i = 1; i <= 29; i++) begin
         tick();
         if (game_over) early = 1'b1;
         if (i == 10) secs_at10 = seconds_left;
      end
      checks++;
      if (early !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early: game_over seen before cycle 30");
      end
      checks++;
      if (secs_at10 !== 8'd2) begin
         errors++;
         $display("FAIL second_tick: secs after 10 cycles=%0d expected 2", secs_at10);
      end
      tick();
      checks++;
      if ({game_over, playing} !== 2'b10 || seconds_left !== 8'd0) begin
         errors++;
         $display("FAIL timeout: game_over=%0d playing=%0d secs=%0d expected 1 0 0", game_over, playing, seconds_left);
      end
      tick();
      checks++;
      if (game_over !== 1'b0) begin
         errors++;
         $display("FAIL timeout_pulse_width: game_over=%0d expected 0", game_over);
      end
      start = 1'b0;
      $display("timeout: round ended after 30 cycles, secs=%0d", seconds_left);
   endtask

   task automatic test_correct_hit;
      go_play();
      mole_pos = 4'b0100; keys = 4'b0100;
      tick();
      checks++;
      if ({correct_hit, wrong_hit, game_over, mole_clear} !== 4'b1001 || score !== 8'd1) begin
         errors++;
         $display("FAIL correct_hit: pulses=%b score=%0d expected 1001 and 1", {correct_hit, wrong_hit, game_over, mole_clear}, score);
      end
      tick();
      checks++;
      if ({correct_hit, wrong_hit, mole_clear} !== 3'b000 || score !== 8'd1) begin
         errors++;
         $display("FAIL held_key: pulses=%b score=%0d expected 000 and 1", {correct_hit, wrong_hit, mole_clear}, score);
      end
      keys = 4'b0000;
      tick();
      $display("correct_hit: score=%0d", score);
   endtask

   task automatic test_wrong_hits;
      go_play();
      mole_pos = 4'b0100; keys = 4'b0001;
      tick();
      checks++;
      if ({correct_hit, wrong_hit, game_over} !== 3'b010 || misses !== 3'd1) begin
         errors++;
         $display("FAIL wrong_key: pulses=%b misses=%0d expected 010 and 1", {correct_hit, wrong_hit, game_over}, misses);
      end
      keys = 4'b0000;
      tick();
      keys = 4'b0110;
      tick();
      checks++;
      if ({correct_hit, wrong_hit, game_over} !== 3'b010 || misses !== 3'd2) begin
         errors++;
         $display("FAIL multi_key: pulses=%b misses=%0d expected 010 and 2", {correct_hit, wrong_hit, game_over}, misses);
      end
      keys = 4'b0000; mole_pos = 4'b0000;
      tick();
      keys = 4'b0001;
      tick();
      checks++;
      if ({correct_hit, wrong_hit, game_over, playing} !== 4'b0110 || misses !== 3'd3) begin
         errors++;
         $display("FAIL max_misses: pulses=%b misses=%0d expected 0110 and 3", {correct_hit, wrong_hit, game_over, playing}, misses);
      end
      keys = 4'b0000;
      tick();
      keys = 4'b0010;
      tick();
      checks++;
      if ({correct_hit, wrong_hit, game_over} !== 3'b000 || misses !== 3'd3) begin
         errors++;
         $display("FAIL key_in_over: pulses=%b misses=%0d expected 000 and 3", {correct_hit, wrong_hit, game_over}, misses);
      end
      keys = 4'b0000;
      $display("wrong_hits: misses=%0d playing=%0d", misses, playing);
   endtask

   task automatic test_expiry_collision;
      go_play();
      for (int i = 0; i < 28; i++) tick();
      checks++;
      if (seconds_left !== 8'd1 || playing !== 1'b1) begin
         errors++;
         $display("FAIL pre_expiry: secs=%0d playing=%0d expected 1 and 1", seconds_left, playing);
      end
      mole_pos = 4'b0100; keys = 4'b0100;
      tick();
      checks++;
      if ({correct_hit, wrong_hit, game_over, mole_clear} !== 4'b0010 ||
          score !== 8'd0 || misses !== 3'd0 || seconds_left !== 8'd0) begin
         errors++;
         $display("FAIL expiry_wins: pulses=%b score=%0d misses=%0d secs=%0d expected 0010 0 0 0",
                  {correct_hit, wrong_hit, game_over, mole_clear}, score, misses, seconds_left);
      end
      keys = 4'b0000;
      tick();
      $display("expiry_collision: game_over only, score=%0d misses=%0d", score, misses);
   endtask

   task automatic test_saturation;
      go_play();
      for (int k = 0; k < 255; k++) begin
         keys = (k % 2 == 1) ? 4'b0010 : 4'b0001;
         mole_pos = keys;
         tick();
      end
      checks++;
      if (s_score !== 8'd255) begin
         errors++;
         $display("FAIL score_255: got %0d expected 255", s_score);
      end
      keys = 4'b0010; mole_pos = 4'b0010;
      tick();
      checks++;
      if (s_correct !== 1'b1 || s_score !== 8'd255) begin
         errors++;
         $display("FAIL saturate: correct_hit=%0d score=%0d expected 1 and 255", s_correct, s_score);
      end
      keys = 4'b0000;
      $display("saturation: score=%0d", s_score);
   endtask

   task automatic test_reset_midround;
      go_play();
      for (int k = 0; k < 5; k++) begin
         keys = (k % 2 == 1) ? 4'b0010 : 4'b0001;
         mole_pos = keys;
         tick();
      end
      checks++;
      if (score !== 8'd5) begin
         errors++;
         $display("FAIL score_5: got %0d expected 5", score);
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({correct_hit, wrong_hit, game_over, mole_clear, playing} !== 5'b00000 ||
          score !== 8'd0 || misses !== 3'd0 || seconds_left !== 8'd0) begin
         errors++;
         $display("FAIL midround_reset: flags=%b score=%0d misses=%0d secs=%0d expected all 0",
                  {correct_hit, wrong_hit, game_over, mole_clear, playing}, score, misses, seconds_left);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({correct_hit, wrong_hit, playing} !== 3'b000) begin
         errors++;
         $display("FAIL held_key_idle: flags=%b expected 000", {correct_hit, wrong_hit, playing});
      end
      keys = 4'b0000;
      tick();
      keys = 4'b0100; mole_pos = 4'b0100;
      tick();
      checks++;
      if ({correct_hit, wrong_hit, mole_clear} !== 3'b000 || score !== 8'd0) begin
         errors++;
         $display("FAIL key_in_idle: pulses=%b score=%0d expected 000 and 0", {correct_hit, wrong_hit, mole_clear}, score);
      end
      keys = 4'b0000; start = 1'b1;
      tick();
      checks++;
      if (playing !== 1'b1 || score !== 8'd0 || misses !== 3'd0 || seconds_left !== 8'd3) begin
         errors++;
         $display("FAIL restart: playing=%0d score=%0d misses=%0d secs=%0d expected 1 0 0 3",
                  playing, score, misses, seconds_left);
      end
      start = 1'b0;
      $display("reset_midround: restarted with score=%0d", score);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; keys = 4'b0000; mole_pos = 4'b0000;
      #1;
      test_reset();
      test_timeout();
      test_correct_hit();
      test_wrong_hits();
      test_expiry_collision();
      test_saturation();
      test_reset_midround();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
